branch_resolve_unit: RTL and testbench

- EX-stage counterpart of the fetch-side branch predictor.
- Evaluates each control instruction in EX: computes the actual direction and target, and compares them with the prediction carried down the pipe.
- Sends a one-cycle update packet back to the predictor, plus a redirect PC and a multi-cycle flush to the front end on misprediction.
- Sits between the ID/EX register and the IF PC mux.

---
 rtl/bru_pkg.sv | 20 ++
 rtl/branch_cmp.sv | 24 ++
 rtl/branch_resolve_unit.sv | 176 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared decode constants and FSM state type for the EX-stage branch resolve unit.
package bru_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/branch_cmp.sv
// Conditional-branch direction evaluator; reserved funct3 encodings resolve not-taken.
module branch_cmp
    import bru_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        taken_c
);

    always_comb begin
        taken_c = 1'b0;
        case (funct3)
            F3_BEQ:  taken_c = (rs1 == rs2);
            F3_BNE:  taken_c = (rs1 != rs2);
            F3_BLT:  taken_c = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken_c = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken_c = (rs1 <  rs2);
            F3_BGEU: taken_c = (rs1 >= rs2);
            default: taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: predictor update, redirect and front-end flush.
// Optional performance counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit #(
    parameter int unsigned PC_W         = 12,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            EX_VALID,
    input  logic [31:0]     INST,
    input  logic [PC_W-1:0] PC,
    input  logic [31:0]     RS1_VAL,
    input  logic [31:0]     RS2_VAL,
    input  logic            PRED_TAKEN,
    input  logic [PC_W-1:0] PRED_TARGET,
    output logic            UPD_VALID,
    output logic [PC_W-1:0] UPD_PC,
    output logic            UPD_TAKEN,
    output logic [PC_W-1:0] UPD_TARGET,
    output logic            REDIRECT,
    output logic [PC_W-1:0] REDIRECT_PC,
    output logic            FLUSH,
    output logic [31:0]     CTRL_CNT,
    output logic [31:0]     MISP_CNT
);
    import bru_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic [6:0]      opcode;
    logic            is_br, is_jal, is_jalr, is_ctrl;
    logic [31:0]     b_imm, j_imm, i_imm, jalr_sum;
    logic            br_taken_c, taken, misp;
    logic [PC_W-1:0] target, fall_thru;

    branch_cmp u_cmp (
        .funct3  (INST[14:12]),
        .rs1     (RS1_VAL),
        .rs2     (RS2_VAL),
        .taken_c (br_taken_c)
    );

    // Decode, target generation and mispredict detection.
    always_comb begin
        opcode   = INST[6:0];
        is_br    = (opcode == OP_BRANCH);
        is_jal   = (opcode == OP_JAL);
        is_jalr  = (opcode == OP_JALR);
        is_ctrl  = is_br | is_jal | is_jalr;
        b_imm    = {{19{INST[31]}}, INST[31], INST[7], INST[30:25], INST[11:8], 1'b0};
        j_imm    = {{11{INST[31]}}, INST[31], INST[19:12], INST[20], INST[30:21], 1'b0};
        i_imm    = {{20{INST[31]}}, INST[31:20]};
        jalr_sum = RS1_VAL + i_imm;
        taken    = is_br ? br_taken_c : (is_jal | is_jalr);
        if (is_jalr)
            target = PC_W'(jalr_sum) & ~PC_W'(1);
        else if (is_jal)
            target = PC + PC_W'(j_imm);
        else
            target = PC + PC_W'(b_imm);
        fall_thru = PC + PC_W'(4);
        misp = is_ctrl && ((taken != PRED_TAKEN) || (taken && (target != PRED_TARGET)));
    end

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            upd_valid_q, upd_valid_d;
    logic [PC_W-1:0] upd_pc_q, upd_pc_d;
    logic            upd_taken_q, upd_taken_d;
    logic [PC_W-1:0] upd_target_q, upd_target_d;
    logic            redirect_q, redirect_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
    logic            flush_q, flush_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        upd_valid_d   = 1'b0;
        upd_pc_d      = upd_pc_q;
        upd_taken_d   = upd_taken_q;
        upd_target_d  = upd_target_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        flush_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (EX_VALID && is_ctrl) begin
                    upd_valid_d  = 1'b1;
                    upd_pc_d     = PC;
                    upd_taken_d  = taken;
                    upd_target_d = target;
                    if (misp) begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = taken ? target : fall_thru;
                        cnt_d         = CNT_W'(FLUSH_CYCLES);
                        state_d       = bru_pkg::FLUSH;
                        flush_d       = 1'b1;
                    end
                end
            end
            bru_pkg::FLUSH: begin
                // Wrong-path instructions are dropped while the front end refills.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1))
                    state_d = IDLE;
                else
                    flush_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
            upd_target_q  <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
            upd_target_q  <= upd_target_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            flush_q       <= flush_d;
        end
    end

    assign UPD_VALID   = upd_valid_q;
    assign UPD_PC      = upd_pc_q;
    assign UPD_TAKEN   = upd_taken_q;
    assign UPD_TARGET  = upd_target_q;
    assign REDIRECT    = redirect_q;
    assign REDIRECT_PC = redirect_pc_q;
    assign FLUSH       = flush_q;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] ctrl_cnt_q, ctrl_cnt_d;
    logic [31:0] misp_cnt_q, misp_cnt_d;

    // Saturating counters advance together with the strobes they count.
    always_comb begin
        ctrl_cnt_d = ctrl_cnt_q;
        misp_cnt_d = misp_cnt_q;
        if (upd_valid_d && (ctrl_cnt_q != 32'hFFFF_FFFF))
            ctrl_cnt_d = ctrl_cnt_q + 32'd1;
        if (redirect_d && (misp_cnt_q != 32'hFFFF_FFFF))
            misp_cnt_d = misp_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            ctrl_cnt_q <= '0;
            misp_cnt_q <= '0;
        end else begin
            ctrl_cnt_q <= ctrl_cnt_d;
            misp_cnt_q <= misp_cnt_d;
        end
    end

    assign CTRL_CNT = ctrl_cnt_q;
    assign MISP_CNT = misp_cnt_q;
`else
    assign CTRL_CNT = 32'd0;
    assign MISP_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; counter expectations follow BRU_PERF_CNT_EN.
module tb_branch_resolve_unit;

    logic        CLK;
    logic        RSTn;
    logic        EX_VALID;
    logic [31:0] INST;
    logic [11:0] PC;
    logic [31:0] RS1_VAL;
    logic [31:0] RS2_VAL;
    logic        PRED_TAKEN;
    logic [11:0] PRED_TARGET;
    logic        UPD_VALID;
    logic [11:0] UPD_PC;
    logic        UPD_TAKEN;
    logic [11:0] UPD_TARGET;
    logic        REDIRECT;
    logic [11:0] REDIRECT_PC;
    logic        FLUSH;
    logic [31:0] CTRL_CNT;
    logic [31:0] MISP_CNT;

    int n_checks = 0;
    int n_errors = 0;

    branch_resolve_unit #(.PC_W(12), .FLUSH_CYCLES(2)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .EX_VALID    (EX_VALID),
        .INST        (INST),
        .PC          (PC),
        .RS1_VAL     (RS1_VAL),
        .RS2_VAL     (RS2_VAL),
        .PRED_TAKEN  (PRED_TAKEN),
        .PRED_TARGET (PRED_TARGET),
        .UPD_VALID   (UPD_VALID),
        .UPD_PC      (UPD_PC),
        .UPD_TAKEN   (UPD_TAKEN),
        .UPD_TARGET  (UPD_TARGET),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .FLUSH       (FLUSH),
        .CTRL_CNT    (CTRL_CNT),
        .MISP_CNT    (MISP_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    task automatic drive(input logic [31:0] inst, input logic [11:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic pt, input logic [11:0] ptgt);
        EX_VALID    = 1'b1;
        INST        = inst;
        PC          = pc;
        RS1_VAL     = rs1;
        RS2_VAL     = rs2;
        PRED_TAKEN  = pt;
        PRED_TARGET = ptgt;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".upd_valid"},   32'(UPD_VALID),   32'd0);
        check({tag, ".upd_pc"},      32'(UPD_PC),      32'd0);
        check({tag, ".upd_taken"},   32'(UPD_TAKEN),   32'd0);
        check({tag, ".upd_target"},  32'(UPD_TARGET),  32'd0);
        check({tag, ".redirect"},    32'(REDIRECT),    32'd0);
        check({tag, ".redirect_pc"}, 32'(REDIRECT_PC), 32'd0);
        check({tag, ".flush"},       32'(FLUSH),       32'd0);
        check({tag, ".ctrl_cnt"},    CTRL_CNT,         32'd0);
        check({tag, ".misp_cnt"},    MISP_CNT,         32'd0);
    endtask

    initial begin
        RSTn = 1'b0; EX_VALID = 1'b0; INST = '0; PC = '0;
        RS1_VAL = '0; RS2_VAL = '0; PRED_TAKEN = 1'b0; PRED_TARGET = '0;
        repeat (2) @(negedge CLK);
        check_all_zero("reset");
        RSTn = 1'b1;

        // BEQ taken, correctly predicted
        drive(enc_b(3'b000, 13'd16), 12'h010, 32'd5, 32'd5, 1'b1, 12'h020);
        @(negedge CLK);
        check("beq.upd_valid",  32'(UPD_VALID),  32'd1);
        check("beq.upd_pc",     32'(UPD_PC),     32'h010);
        check("beq.upd_taken",  32'(UPD_TAKEN),  32'd1);
        check("beq.upd_target", 32'(UPD_TARGET), 32'h020);
        check("beq.redirect",   32'(REDIRECT),   32'd0);
        check("beq.flush",      32'(FLUSH),      32'd0);
        EX_VALID = 1'b0;
        @(negedge CLK);
        check("beq.pulse_end",   32'(UPD_VALID),  32'd0);
        check("beq.target_hold", 32'(UPD_TARGET), 32'h020);

        // Non-control instruction (ADDI) produces nothing
        drive(32'h0050_0093, 12'h014, 32'd0, 32'd0, 1'b1, 12'h000);
        @(negedge CLK);
        check("addi.upd_valid", 32'(UPD_VALID), 32'd0);
        check("addi.redirect",  32'(REDIRECT),  32'd0);
        check("addi.upd_pc",    32'(UPD_PC),    32'h010);
        EX_VALID = 1'b0;

        // BNE with equal operands: not taken, predicted not taken
        drive(enc_b(3'b001, 13'd16), 12'h018, 32'd7, 32'd7, 1'b0, 12'h01C);
        @(negedge CLK);
        check("bne.upd_taken",  32'(UPD_TAKEN),  32'd0);
        check("bne.upd_pc",     32'(UPD_PC),     32'h018);
        check("bne.upd_target", 32'(UPD_TARGET), 32'h028);
        check("bne.redirect",   32'(REDIRECT),   32'd0);
        EX_VALID = 1'b0;

        // BGE signed: -5 >= 3 is false
        drive(enc_b(3'b101, 13'd16), 12'h01C, 32'hFFFF_FFFB, 32'd3, 1'b0, 12'h020);
        @(negedge CLK);
        check("bge.upd_valid", 32'(UPD_VALID), 32'd1);
        check("bge.upd_taken", 32'(UPD_TAKEN), 32'd0);
        check("bge.redirect",  32'(REDIRECT),  32'd0);
        EX_VALID = 1'b0;

        // BLT signed taken, predicted not taken -> redirect + 2-cycle flush
        drive(enc_b(3'b100, 13'h020), 12'h040, 32'hFFFF_FFFF, 32'd1, 1'b0, 12'h044);
        @(negedge CLK);
        check("blt.upd_valid",   32'(UPD_VALID),   32'd1);
        check("blt.upd_taken",   32'(UPD_TAKEN),   32'd1);
        check("blt.redirect",    32'(REDIRECT),    32'd1);
        check("blt.redirect_pc", 32'(REDIRECT_PC), 32'h060);
        check("blt.flush1",      32'(FLUSH),       32'd1);
        drive(enc_b(3'b000, 13'd16), 12'h044, 32'd1, 32'd1, 1'b0, 12'h048);
        @(negedge CLK);
        check("blt.wrongpath_upd", 32'(UPD_VALID), 32'd0);
        check("blt.wrongpath_rd",  32'(REDIRECT),  32'd0);
        check("blt.flush2",        32'(FLUSH),     32'd1);
        check("blt.upd_pc_hold",   32'(UPD_PC),    32'h040);
        EX_VALID = 1'b0;
        @(negedge CLK);
        check("blt.flush_drop", 32'(FLUSH), 32'd0);

        // BLTU: 0xFFFFFFFF < 1 unsigned is false, predicted taken
        drive(enc_b(3'b110, 13'h020), 12'h040, 32'hFFFF_FFFF, 32'd1, 1'b1, 12'h060);
        @(negedge CLK);
        check("bltu.upd_taken",   32'(UPD_TAKEN),   32'd0);
        check("bltu.upd_target",  32'(UPD_TARGET),  32'h060);
        check("bltu.redirect",    32'(REDIRECT),    32'd1);
        check("bltu.redirect_pc", 32'(REDIRECT_PC), 32'h044);
        EX_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        check("bltu.flush_drop", 32'(FLUSH), 32'd0);

        // JALR: target bit0 cleared, wrong predicted target
        drive(enc_jalr(12'd0), 12'h200, 32'h0000_0103, 32'd0, 1'b1, 12'h100);
        @(negedge CLK);
        check("jalr.upd_target",  32'(UPD_TARGET),  32'h102);
        check("jalr.redirect",    32'(REDIRECT),    32'd1);
        check("jalr.redirect_pc", 32'(REDIRECT_PC), 32'h102);
        EX_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        check("jalr.flush_drop", 32'(FLUSH), 32'd0);

        // JAL wrapping past top of PC space, then reset while flushing
        drive(enc_j(21'd8), 12'hFFC, 32'd0, 32'd0, 1'b0, 12'h000);
        @(negedge CLK);
        check("jal.upd_target",  32'(UPD_TARGET),  32'h004);
        check("jal.redirect_pc", 32'(REDIRECT_PC), 32'h004);
        check("jal.flush",       32'(FLUSH),       32'd1);
        EX_VALID = 1'b0;
        RSTn = 1'b0;
        @(negedge CLK);
        check_all_zero("midflush_rst");
        RSTn = 1'b1;

        // Three control instructions, one mispredict
        drive(enc_b(3'b000, 13'd16), 12'h010, 32'd5, 32'd5, 1'b1, 12'h020);
        @(negedge CLK);
        EX_VALID = 1'b0;
        drive(enc_j(21'd8), 12'h100, 32'd0, 32'd0, 1'b1, 12'h108);
        @(negedge CLK);
        check("perf.jal_redirect", 32'(REDIRECT), 32'd0);
        EX_VALID = 1'b0;
        drive(enc_b(3'b001, 13'd16), 12'h108, 32'd1, 32'd2, 1'b0, 12'h10C);
        @(negedge CLK);
        check("perf.bne_redirect", 32'(REDIRECT), 32'd1);
        EX_VALID = 1'b0;
        repeat (3) @(negedge CLK);
`ifdef BRU_PERF_CNT_EN
        check("perf.ctrl_cnt", CTRL_CNT, 32'd3);
        check("perf.misp_cnt", MISP_CNT, 32'd1);
`else
        check("perf.ctrl_cnt", CTRL_CNT, 32'd0);
        check("perf.misp_cnt", MISP_CNT, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
